// File: rtl/display_scan_controller.sv
// display_scan_controller
//   Scan sequencer for the 6-digit 7-segment clock display. It steps
//   o_seg_select through the digits and produces one-hot common-digit enables.
//   Each digit slot starts with a blanked dead time. After that the digit is
//   lit for a brightness-controlled number of refresh ticks. A slot always
//   lasts exactly SLOT_TICKS ticks, whatever the brightness.
//
//   Optional feature macro: LEADING_ZERO_BLANK_EN
//     When this macro is defined, digit 0 (hours MSD) stays dark while i_bcd is 0.
//
// Ports
//   i_clk          system clock
//   i_reset_n      synchronous active-low reset
//   i_en           scan enable; low forces the display dark and returns to IDLE
//   i_refresh_stb  one-cycle refresh tick from the prescaler
//   i_brightness   lit ticks per slot after dead time (0 = dark)
//   i_bcd          BCD digit currently selected by o_seg_select
//   o_seg_select   digit index to the BCD mux
//   o_digit_en     registered one-hot digit enable
//   o_latch        one-cycle pulse when o_seg_select takes a new value
//
// State | meaning
//   IDLE  | scan disabled, display dark
//   BLANK | dead time at the start of a slot, digit dark
//   ON    | selected digit lit
//   OFF   | remainder of the slot, digit dark
//
// DEAD_TICKS must be at least 1.

module display_scan_controller #(
  parameter int NUM_DIGITS = 6,
  parameter int SLOT_TICKS = 16,
  parameter int DEAD_TICKS = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_en,
  input  logic                  i_refresh_stb,
  input  logic [3:0]            i_brightness,
  input  logic [3:0]            i_bcd,
  output logic [3:0]            o_seg_select,
  output logic [NUM_DIGITS-1:0] o_digit_en,
  output logic                  o_latch
);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_ON, S_OFF} state_t;

  localparam logic [4:0] LP_DEAD   = 5'(DEAD_TICKS);
  localparam logic [4:0] LP_SLOT   = 5'(SLOT_TICKS);
  localparam logic [3:0] LP_TC     = 4'(SLOT_TICKS - 1);
  localparam logic [3:0] LP_ON_MAX = 4'(SLOT_TICKS - DEAD_TICKS);
  localparam logic [3:0] LP_LAST   = 4'(NUM_DIGITS - 1);

  state_t                r_state, w_state_nxt;
  logic [3:0]            r_tick, w_tick_nxt;
  logic [3:0]            r_on_len, w_on_len_nxt;
  logic [3:0]            w_seg_nxt;
  logic                  w_latch_nxt;
  logic [NUM_DIGITS-1:0] w_digit_en_nxt;

  logic [4:0] w_tick_inc;
  logic [4:0] w_on_end;
  logic [3:0] w_on_clamp;
  logic [3:0] w_seg_inc;
  logic       w_lead_blank;

  assign w_tick_inc = {1'b0, r_tick} + 5'd1;
  // ON ends after r_on_len strobes, so it ends at tick DEAD + r_on_len.
  // This is a 5-bit value so that a full-length ON can end at SLOT_TICKS.
  assign w_on_end   = LP_DEAD + {1'b0, r_on_len};
  assign w_on_clamp = (i_brightness > LP_ON_MAX) ? LP_ON_MAX : i_brightness;
  assign w_seg_inc  = (o_seg_select == LP_LAST) ? 4'd0 : o_seg_select + 4'd1;

`ifdef LEADING_ZERO_BLANK_EN
  assign w_lead_blank = (w_seg_nxt == 4'd0) && (i_bcd == 4'd0);
`else
  logic w_unused_bcd;
  assign w_unused_bcd = ^i_bcd;
  assign w_lead_blank = 1'b0;
`endif

  // State register; the digit enable and latch are registered here too
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state      <= S_IDLE;
      r_tick       <= 4'd0;
      r_on_len     <= 4'd0;
      o_seg_select <= 4'd0;
      o_digit_en   <= '0;
      o_latch      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_tick       <= w_tick_nxt;
      r_on_len     <= w_on_len_nxt;
      o_seg_select <= w_seg_nxt;
      o_digit_en   <= w_digit_en_nxt;
      o_latch      <= w_latch_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt  = r_state;
    w_tick_nxt   = r_tick;
    w_on_len_nxt = r_on_len;
    w_seg_nxt    = o_seg_select;
    w_latch_nxt  = 1'b0;
    if (!i_en) begin
      // Disable wins over a coincident strobe
      w_state_nxt = S_IDLE;
      w_tick_nxt  = 4'd0;
      w_seg_nxt   = 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_BLANK;
          w_tick_nxt  = 4'd0;
          w_seg_nxt   = 4'd0;
          w_latch_nxt = 1'b1;
        end
        S_BLANK: begin
          if (i_refresh_stb) begin
            w_tick_nxt = w_tick_inc[3:0];
            if (w_tick_inc == LP_DEAD) begin
              // Brightness is sampled only here, so a change waits for the next slot
              w_on_len_nxt = w_on_clamp;
              w_state_nxt  = (w_on_clamp == 4'd0) ? S_OFF : S_ON;
            end
          end
        end
        S_ON: begin
          if (i_refresh_stb) begin
            w_tick_nxt = w_tick_inc[3:0];
            if (w_tick_inc == w_on_end) begin
              if (w_tick_inc == LP_SLOT) begin
                w_state_nxt = S_BLANK;
                w_tick_nxt  = 4'd0;
                w_seg_nxt   = w_seg_inc;
                w_latch_nxt = 1'b1;
              end else begin
                w_state_nxt = S_OFF;
              end
            end
          end
        end
        S_OFF: begin
          if (i_refresh_stb) begin
            if (r_tick == LP_TC) begin
              w_state_nxt = S_BLANK;
              w_tick_nxt  = 4'd0;
              w_seg_nxt   = w_seg_inc;
              w_latch_nxt = 1'b1;
            end else begin
              w_tick_nxt = w_tick_inc[3:0];
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_tick_nxt  = 4'd0;
          w_seg_nxt   = 4'd0;
        end
      endcase
    end
  end

  // Output logic: a digit is lit only in the cycles the FSM spends in ON
  always_comb begin
    w_digit_en_nxt = '0;
    if (w_state_nxt == S_ON && !w_lead_blank)
      w_digit_en_nxt = NUM_DIGITS'(1) << w_seg_nxt;
  end

endmodule
